// File: rtl/ldpc_pkg.sv
// ldpc_pkg: constants shared by the LDPC check-node and variable-node units.
// Holds default message width, check degree, the offset used by offset
// min-sum (enabled with CNU_OFFSET_EN), and the CNU FSM state encoding.
package ldpc_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CNU_D      = 6;
  localparam int unsigned CNU_OFFSET = 1;

  localparam int unsigned ST_W       = 2;
  localparam logic [ST_W-1:0] ST_COLLECT = 2'd0;
  localparam logic [ST_W-1:0] ST_CALC    = 2'd1;
  localparam logic [ST_W-1:0] ST_OUT     = 2'd2;

endpackage

// File: rtl/cnu_minfind.sv
// cnu_minfind: running two-minimum search over the magnitudes of the
// variable-to-check messages of one check, plus sign parity and per-edge
// sign capture.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clear_i       reinitialise accumulators (end of a check)
//   accept_i      q_i is an accepted edge this cycle
//   q_i           two's-complement message
//   edge_i        index of the accepted edge
//   min1_o/min2_o smallest / second-smallest magnitude seen
//   idx_o         edge index of min1_o (earliest edge wins ties)
//   parity_o      XOR of accepted sign bits
//   signs_o       sign bit of every edge
module cnu_minfind
  import ldpc_pkg::*;
#(
  parameter int unsigned data_w = DATA_W,
  parameter int unsigned D      = CNU_D
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear_i,
  input  logic                                 accept_i,
  input  logic [data_w-1:0]                    q_i,
  input  logic [((D > 1) ? $clog2(D) : 1)-1:0] edge_i,
  output logic [data_w-2:0]                    min1_o,
  output logic [data_w-2:0]                    min2_o,
  output logic [((D > 1) ? $clog2(D) : 1)-1:0] idx_o,
  output logic                                 parity_o,
  output logic [D-1:0]                         signs_o
);

  localparam int unsigned cnt_w = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned mag_w = data_w - 1;
  localparam logic [mag_w-1:0] mag_max = '1;

  logic [mag_w-1:0] mag;
  logic [mag_w-1:0] min1_q, min1_d;
  logic [mag_w-1:0] min2_q, min2_d;
  logic [cnt_w-1:0] idx_q, idx_d;
  logic             parity_q, parity_d;
  logic [D-1:0]     signs_q, signs_d;

  // |q| on mag_w bits; the most negative code saturates to the max magnitude
  always_comb begin
    if (!q_i[data_w-1]) begin
      mag = q_i[mag_w-1:0];
    end else if (q_i[mag_w-1:0] == '0) begin
      mag = mag_max;
    end else begin
      mag = ~q_i[mag_w-1:0] + mag_w'(1);
    end
  end

  // Accumulator update; strict compares keep the earliest edge on ties
  always_comb begin
    min1_d   = min1_q;
    min2_d   = min2_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    signs_d  = signs_q;
    if (clear_i) begin
      min1_d   = mag_max;
      min2_d   = mag_max;
      idx_d    = '0;
      parity_d = 1'b0;
      signs_d  = '0;
    end else if (accept_i) begin
      parity_d = parity_q ^ q_i[data_w-1];
      for (int unsigned i = 0; i < D; i++) begin
        if (edge_i == cnt_w'(i)) begin
          signs_d[i] = q_i[data_w-1];
        end
      end
      if (mag < min1_q) begin
        min2_d = min1_q;
        min1_d = mag;
        idx_d  = edge_i;
      end else if (mag < min2_q) begin
        min2_d = mag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min1_q   <= mag_max;
      min2_q   <= mag_max;
      idx_q    <= '0;
      parity_q <= 1'b0;
      signs_q  <= '0;
    end else begin
      min1_q   <= min1_d;
      min2_q   <= min2_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      signs_q  <= signs_d;
    end
  end

  assign min1_o   = min1_q;
  assign min2_o   = min2_q;
  assign idx_o    = idx_q;
  assign parity_o = parity_q;
  assign signs_o  = signs_q;

endmodule

// File: rtl/check_node_unit.sv
// check_node_unit: min-sum LDPC check node. Collects D variable-to-check
// messages, then produces all D check-to-variable messages at once plus the
// parity-check syndrome. Optional offset min-sum via macro CNU_OFFSET_EN.
// Ports:
//   clk, rst        clock, async active-low reset
//   q, q_valid      input message stream (edges 0..D-1), q_ready accepts
//   r, r_valid      output messages, edge i at r[i*data_w +: data_w]
//   r_ready         consumer takes r
//   syn             1 = parity check failed
module check_node_unit
  import ldpc_pkg::*;
#(
  parameter int unsigned data_w = DATA_W,
  parameter int unsigned D      = CNU_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_w-1:0]     q,
  input  logic                  q_valid,
  output logic                  q_ready,
  output logic [data_w*D-1:0]   r,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic                  syn
);

  localparam int unsigned cnt_w = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned mag_w = data_w - 1;

  logic [ST_W-1:0]     state_q, state_d;
  logic [cnt_w-1:0]    cnt_q, cnt_d;
  logic [data_w*D-1:0] r_q, r_d;
  logic                syn_q, syn_d;
  logic                r_valid_q, r_valid_d;

  logic                accept;
  logic                clear;
  logic [mag_w-1:0]    min1, min2;
  logic [cnt_w-1:0]    idx;
  logic                parity;
  logic [D-1:0]        signs;
  logic [data_w*D-1:0] r_calc;
  logic [mag_w-1:0]    m;
  logic [data_w-1:0]   m_ext;

  assign q_ready = (state_q == ST_COLLECT);
  assign accept  = q_valid && q_ready;

  cnu_minfind #(
    .data_w (data_w),
    .D      (D)
  ) u_minfind (
    .clk      (clk),
    .rst_n    (rst),
    .clear_i  (clear),
    .accept_i (accept),
    .q_i      (q),
    .edge_i   (cnt_q),
    .min1_o   (min1),
    .min2_o   (min2),
    .idx_o    (idx),
    .parity_o (parity),
    .signs_o  (signs)
  );

  // Per-edge output: exclude own edge from the minimum, sign = parity ^ own sign
  always_comb begin
    r_calc = '0;
    m      = '0;
    m_ext  = '0;
    for (int unsigned i = 0; i < D; i++) begin
      m = (idx == cnt_w'(i)) ? min2 : min1;
`ifdef CNU_OFFSET_EN
      m = (m > mag_w'(CNU_OFFSET)) ? (m - mag_w'(CNU_OFFSET)) : '0;
`endif
      m_ext = {1'b0, m};
      r_calc[i*data_w +: data_w] = (parity ^ signs[i]) ? (~m_ext + data_w'(1)) : m_ext;
    end
  end

  // Control FSM: COLLECT D edges, one CALC cycle, hold OUT until consumed
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    syn_d     = syn_q;
    r_valid_d = r_valid_q;
    clear     = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          if (cnt_q == cnt_w'(D - 1)) begin
            cnt_d   = '0;
            state_d = ST_CALC;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end
      end
      ST_CALC: begin
        r_d       = r_calc;
        syn_d     = parity;
        r_valid_d = 1'b1;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          clear     = 1'b1;
          cnt_d     = '0;
          state_d   = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_COLLECT;
      cnt_q     <= '0;
      r_q       <= '0;
      syn_q     <= 1'b0;
      r_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      syn_q     <= syn_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign r       = r_q;
  assign syn     = syn_q;
  assign r_valid = r_valid_q;

endmodule

// File: tb/tb_check_node_unit.sv
// tb_check_node_unit: directed self-checking bench for check_node_unit
// (default data_w=8, D=6). Expected values are hand-computed; the
// CNU_OFFSET_EN build selects the offset min-sum expectations.
module tb_check_node_unit;

  localparam int unsigned DW = 8;
  localparam int unsigned ND = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     q;
  logic              q_valid;
  logic              q_ready;
  logic [DW*ND-1:0]  r;
  logic              r_valid;
  logic              r_ready;
  logic              syn;

  int checks = 0;
  int errors = 0;

  logic [7:0] vec_a[6];
  logic [7:0] vec_b[6];
  logic [7:0] vec_ones[6];
  int         no_gap[6];
  int         gaps[6];
  logic [47:0] exp_a, exp_b, exp_ones;
  logic [47:0] r_hold;

  check_node_unit #(.data_w(DW), .D(ND)) dut (
    .clk     (clk),
    .rst     (rst),
    .q       (q),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .r       (r),
    .r_valid (r_valid),
    .r_ready (r_ready),
    .syn     (syn)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pack6(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5);
    logic [47:0] p;
    p[7:0]   = 8'(a0);
    p[15:8]  = 8'(a1);
    p[23:16] = 8'(a2);
    p[31:24] = 8'(a3);
    p[39:32] = 8'(a4);
    p[47:40] = 8'(a5);
    return p;
  endfunction

  // Present one edge after `gap` idle cycles (garbage on q), wait for accept
  task automatic send_edge(input logic [7:0] v, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      q       = 8'h81;
      q_valid = 1'b0;
    end
    @(negedge clk);
    q       = v;
    q_valid = 1'b1;
    n       = 0;
    while (!q_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_ready", 64'(q_ready), 64'd1);
    @(posedge clk);
  endtask

  // Full check plus latency: r_valid low in CALC, high the cycle after
  task automatic send_check(input logic [7:0] v[6], input int g[6]);
    for (int i = 0; i < 6; i++) begin
      send_edge(v[i], g[i]);
    end
    @(negedge clk);
    q_valid = 1'b0;
    check_eq("lat_calc_rvalid", 64'(r_valid), 64'd0);
    @(negedge clk);
    check_eq("lat_out_rvalid", 64'(r_valid), 64'd1);
  endtask

  task automatic consume();
    @(negedge clk);
    r_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_ready = 1'b0;
    check_eq("post_consume_rvalid", 64'(r_valid), 64'd0);
    check_eq("post_consume_qready", 64'(q_ready), 64'd1);
  endtask

  initial begin
    vec_a    = '{8'd5, 8'hFD, 8'd7, 8'd2, 8'hF7, 8'd4};
    vec_b    = '{8'h80, 8'd1, 8'd1, 8'd10, 8'd10, 8'd10};
    vec_ones = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    no_gap   = '{0, 0, 0, 0, 0, 0};
    gaps     = '{0, 2, 1, 3, 0, 1};
`ifdef CNU_OFFSET_EN
    exp_a    = pack6(1, -1, 1, 2, -1, 1);
    exp_b    = pack6(0, 0, 0, 0, 0, 0);
    exp_ones = pack6(0, 0, 0, 0, 0, 0);
`else
    exp_a    = pack6(2, -2, 2, 3, -2, 2);
    exp_b    = pack6(1, -1, -1, -1, -1, -1);
    exp_ones = pack6(1, 1, 1, 1, 1, 1);
`endif

    rst     = 1'b0;
    q       = '0;
    q_valid = 1'b0;
    r_ready = 1'b0;
    #1;
    check_eq("rst_rvalid", 64'(r_valid), 64'd0);
    check_eq("rst_qready", 64'(q_ready), 64'd1);
    check_eq("rst_r", 64'(r), 64'd0);
    check_eq("rst_syn", 64'(syn), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Basic min-sum check
    send_check(vec_a, no_gap);
    check_eq("a_r", 64'(r), 64'(exp_a));
    check_eq("a_syn", 64'(syn), 64'd0);
    consume();

    // Saturation of -128 and tie rule
    send_check(vec_b, no_gap);
    check_eq("b_r", 64'(r), 64'(exp_b));
    check_eq("b_syn", 64'(syn), 64'd1);
    consume();

    // All-equal magnitudes
    send_check(vec_ones, no_gap);
    check_eq("ones_r", 64'(r), 64'(exp_ones));
    check_eq("ones_syn", 64'(syn), 64'd0);
    consume();

    // Back-pressure in OUT with q_valid asserted
    send_check(vec_b, no_gap);
    r_hold = r;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      q       = 8'd3;
      q_valid = 1'b1;
      check_eq("stall_qready", 64'(q_ready), 64'd0);
      check_eq("stall_rvalid", 64'(r_valid), 64'd1);
      check_eq("stall_r", 64'(r), 64'(r_hold));
    end
    check_eq("stall_r_value", 64'(r), 64'(exp_b));
    @(negedge clk);
    q_valid = 1'b0;
    consume();
    send_check(vec_a, no_gap);
    check_eq("after_stall_r", 64'(r), 64'(exp_a));
    check_eq("after_stall_syn", 64'(syn), 64'd0);
    consume();

    // Reset in the middle of collection
    for (int i = 0; i < 3; i++) begin
      send_edge(vec_b[i], 0);
    end
    @(negedge clk);
    q_valid = 1'b0;
    rst     = 1'b0;
    #1;
    check_eq("midrst_rvalid", 64'(r_valid), 64'd0);
    check_eq("midrst_qready", 64'(q_ready), 64'd1);
    check_eq("midrst_r", 64'(r), 64'd0);
    check_eq("midrst_syn", 64'(syn), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    send_check(vec_a, no_gap);
    check_eq("post_rst_r", 64'(r), 64'(exp_a));
    check_eq("post_rst_syn", 64'(syn), 64'd0);
    consume();

    // Gapped input stream gives the same result
    send_check(vec_a, gaps);
    check_eq("gap_r", 64'(r), 64'(exp_a));
    check_eq("gap_syn", 64'(syn), 64'd0);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
